// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants and FSM state type for the round-robin demux scheduler
package demux_sched_pkg;
  localparam int N_OUT = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/demux_rr_scheduler_if.sv
// demux_rr_scheduler_if: producer stream (in_valid/in_data/in_ready), channel mask cfg_en, per-channel out_ready and held-beat outputs sel/out_data/out_valid
interface demux_rr_scheduler_if #(parameter int DATA_W = 8);
  import demux_sched_pkg::*;
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic in_ready;
  logic [N_OUT-1:0] cfg_en;
  logic [N_OUT-1:0] out_ready;
  logic [SEL_W-1:0] sel;
  logic [DATA_W-1:0] out_data;
  logic [N_OUT-1:0] out_valid;
  modport slave(input in_valid, in_data, cfg_en, out_ready, output in_ready, sel, out_data, out_valid);
  modport master(output in_valid, in_data, cfg_en, out_ready, input in_ready, sel, out_data, out_valid);
endinterface

// File: rtl/demux_rr_scheduler_rr_pick.sv
// rr_pick: first set bit of en at or after ptr, wrapping 7->0; ports ptr, en in; pick, found out
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_OUT-1:0] en,
  output logic [SEL_W-1:0] pick,
  output logic             found
);
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (en[ptr + SEL_W'(i)]) begin
        pick = ptr + SEL_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: round-robin 1:8 demux scheduler; ports clk, rst, bus (slave modport of demux_rr_scheduler_if)
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BURST  = 1
) (
  input logic clk,
  input logic rst,
  demux_rr_scheduler_if.slave bus
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, cur_q, cur_d, pick, pick_rr, scan_ptr;
  logic [7:0] cnt_q, cnt_d, nxt;
  logic [DATA_W-1:0] data_q, data_d;
  logic found, out_fire, in_fire, reuse, close, last;
  // a disabled burst channel closes the burst, so scanning restarts just past it
  rr_pick u_pick (.ptr(scan_ptr), .en(bus.cfg_en), .pick(pick_rr), .found(found));
  always_comb begin
    out_fire = state_q == HOLD && bus.out_ready[sel_q];
    reuse = cnt_q != 8'd0 && bus.cfg_en[cur_q];
    close = cnt_q != 8'd0 && !bus.cfg_en[cur_q];
    scan_ptr = close ? cur_q + 1'b1 : ptr_q;
    bus.in_ready = !rst && found && (state_q == IDLE || out_fire);
    in_fire = bus.in_valid && bus.in_ready;
    pick = reuse ? cur_q : pick_rr;
    nxt = (reuse ? cnt_q : 8'd0) + 8'd1;
    last = nxt == 8'(BURST);
    state_d = in_fire ? HOLD : out_fire ? IDLE : state_q;
    sel_d = in_fire ? pick : sel_q;
    cur_d = in_fire ? pick : cur_q;
    data_d = in_fire ? bus.in_data : data_q;
    cnt_d = in_fire ? (last ? 8'd0 : nxt) : close ? 8'd0 : cnt_q;
    ptr_d = in_fire && last ? pick + 1'b1 : scan_ptr;
  end
  assign bus.sel = sel_q;
  assign bus.out_data = data_q;
  assign bus.out_valid = state_q == HOLD ? N_OUT'(1) << sel_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      data_q <= '0;
      ptr_q <= '0;
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/demux_rr_scheduler.md
# demux_rr_scheduler

Round-robin scheduler for the 1:8 demultiplexer datapath. It accepts a valid/ready input stream, picks one of eight output channels per burst, and drives the demux select together with a one-hot per-channel valid. Channels can be masked off at run time. It sits between a single producer and eight consumers in front of the combinational 1:8 demux.

## Interface
Parameters:
- DATA_W, 8: payload width.
- BURST, 1: beats sent to one channel before the pointer advances (1..255).

Ports:
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a beat.
- in_data  in  DATA_W  producer payload.
- in_ready  out  1  scheduler accepts a beat this cycle.
- cfg_en  in  8  per-channel enable mask; bit i enables channel i.
- out_ready  in  8  per-channel consumer ready.
- sel  out  3  demux select for the held beat (registered).
- out_data  out  DATA_W  held payload (registered).
- out_valid  out  8  one-hot valid; bit sel is set when a beat is held.

## Operation
- One holding register with states IDLE (empty) and HOLD (full).
- Input fire: in_valid && in_ready. Output fire: out_valid[sel] && out_ready[sel].
- in_ready = !rst && (cfg_en != 0) && (state==IDLE || output fire).
- Channel pick at input fire:
  - If a burst is open (beat_cnt != 0) and cfg_en[cur] is set, reuse cur.
  - Otherwise pick the first enabled channel at or after ptr, scanning upward and wrapping 7→0.
- On a pick: sel←pick, out_data←in_data, out_valid←1<<pick, beat_cnt←beat_cnt+1. When beat_cnt reaches BURST, beat_cnt←0 and ptr←pick+1 (mod 8).
- If the burst channel is disabled mid-burst, the burst closes (beat_cnt←0, ptr←cur+1). The beat already held still completes on its original channel.
- Transitions:
  - IDLE→HOLD on input fire.
  - HOLD→HOLD on simultaneous input and output fire.
  - HOLD→IDLE on output fire without input fire.
  - HOLD stalls indefinitely while out_ready[sel]=0. sel, out_data and out_valid stay stable during a stall.
- cfg_en==0: no new beats are accepted. A held beat still drains.
- Reset values: state IDLE, out_valid 0, sel 0, out_data 0, ptr 0, beat_cnt 0, cur 0, in_ready 0 while rst is high.
- Reset mid-transfer drops the held beat. Outputs return to their reset values on the next edge.

## Timing
- Latency: input fire at cycle N gives out_valid at N+1.
- Throughput is 1 beat/cycle while the selected consumer keeps out_ready high.
- in_ready depends combinationally on out_ready[sel] and cfg_en. There is no combinational path from in_valid to any output.
- Pointer and burst-count updates take effect on the edge of the input fire.

## Structure
- Shared package demux_sched_pkg holds:
  - N_OUT=8 and SEL_W=3.
  - The state enum {IDLE, HOLD}.
- Sub-module rr_pick is combinational. Inputs: ptr[2:0], en[7:0]. Outputs: pick[2:0] and found, the first set bit at or after ptr with wrap.
- The top level holds the FSM, holding register, ptr, cur and beat_cnt.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1. Required: in_ready=0, out_valid=0, sel=0. Releasing rst gives in_ready=1 when cfg_en=8'hFF.
- Rotation: BURST=1, cfg_en=8'hFF, all out_ready=1, send 10 beats 0x00..0x09 back to back. Required sel sequence 0,1,…,7,0,1 at one beat per cycle, each beat appearing exactly one cycle after acceptance.
- Mask skip and wrap: cfg_en=8'b1000_0101 with ptr=3. Required sel sequence 7,0,2,7.
- Burst: BURST=3, cfg_en=8'hFF, send 7 beats. Required sel 0,0,0,1,1,1,2. Then clear cfg_en[2] mid-burst; the next beat goes to channel 3.
- Backpressure: out_ready[sel]=0 for 5 cycles while holding data 0xA5. Required: in_ready=0, and sel, out_data and out_valid stay unchanged. Raising out_ready drains the beat, and a new beat is accepted in the same cycle.
- Reset mid-transfer: assert rst while HOLD stalls. Next cycle: out_valid=0, ptr=0. The dropped beat never appears on any channel.
